// File: rtl/sensor_scan_ctrl.sv
// Linear image sensor scan controller: sensor clock divider, ST integration pulse, pixel capture on TRG, EOC/timeout handling.
// Optional frame counter output FRAME_CNT is built only when SCAN_CTRL_FRAME_CNT_EN is defined.
module sensor_scan_ctrl #(
    parameter int DIV       = 8,
    parameter int INTEG_CYC = 6000,
    parameter int NPIX      = 1024,
    parameter int TIMEOUT   = 4096
) (
    input  logic        FPGA_CLK,
    input  logic        FPGA_RST,
    input  logic        START,
    input  logic        CONT,
    input  logic        TRG,
    input  logic        EOC,
    input  logic [11:0] ADC_DATA,
    output logic        SENSOR_CLK,
    output logic        ST,
    output logic        PIX_VALID,
    output logic [11:0] PIX_DATA,
    output logic [10:0] PIX_INDEX,
    output logic        FRAME_DONE,
    output logic        BUSY,
`ifdef SCAN_CTRL_FRAME_CNT_EN
    output logic [15:0] FRAME_CNT,
`endif
    output logic        ERR_TIMEOUT
);

    localparam int DW   = $clog2(DIV);
    localparam int CMAX = (INTEG_CYC > TIMEOUT) ? INTEG_CYC : TIMEOUT;
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic [2:0] {IDLE, INTEG, READOUT, DONE, ERR} state_t;

    state_t          state_q;
    logic [DW-1:0]   div_q;
    logic            sclk_q;
    logic            sclk_rise;
    logic [CW-1:0]   cyc_q;
    logic [10:0]     pix_cnt_q;
    logic            start_pend_q;
    logic            st_q, pix_valid_q, frame_done_q, busy_q, err_q;
    logic [11:0]     pix_data_q;
    logic [10:0]     pix_index_q;
    logic            go_integ;
    logic [1:0]      async_in;
    logic [1:0]      rise;
`ifdef SCAN_CTRL_FRAME_CNT_EN
    logic [15:0]     frame_cnt_q;
    assign FRAME_CNT = frame_cnt_q;
`endif

    // Free-running divider; sclk_rise marks the cycle whose edge drives SENSOR_CLK 0->1.
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (div_q == DW'(DIV - 1)) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            div_q  <= div_q + DW'(1);
        end
    end
    assign sclk_rise = (div_q == DW'(DIV - 1)) && !sclk_q;

    // Bit 0 = TRG, bit 1 = EOC: two sync flops plus one history flop for edge detection.
    assign async_in = {EOC, TRG};
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic [2:0] sync_q;
        always_ff @(posedge FPGA_CLK) begin
            if (FPGA_RST) sync_q <= '0;
            else          sync_q <= {sync_q[1:0], async_in[gi]};
        end
        assign rise[gi] = sync_q[1] & ~sync_q[2];
    end

    assign go_integ = sclk_rise &&
                      (((state_q == IDLE) && (START || start_pend_q)) ||
                       ((state_q == DONE) && CONT));

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            pix_cnt_q    <= '0;
            start_pend_q <= 1'b0;
            st_q         <= 1'b0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            pix_data_q   <= '0;
            pix_index_q  <= '0;
`ifdef SCAN_CTRL_FRAME_CNT_EN
            frame_cnt_q  <= '0;
`endif
        end else begin
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        start_pend_q <= 1'b1;
                        err_q        <= 1'b0;
                    end
                end
                INTEG: begin
                    if (sclk_rise) begin
                        if (cyc_q == CW'(INTEG_CYC - 1)) begin
                            state_q <= READOUT;
                            st_q    <= 1'b0;
                            cyc_q   <= '0;
                        end else begin
                            cyc_q   <= cyc_q + CW'(1);
                        end
                    end
                end
                READOUT: begin
                    if (rise[0] && (pix_cnt_q < 11'(NPIX))) begin
                        pix_data_q  <= ADC_DATA;
                        pix_index_q <= pix_cnt_q;
                        pix_valid_q <= 1'b1;
                        pix_cnt_q   <= pix_cnt_q + 11'd1;
                    end
                    // EOC wins over a timeout expiring in the same cycle.
                    if (rise[1]) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
`ifdef SCAN_CTRL_FRAME_CNT_EN
                        frame_cnt_q  <= frame_cnt_q + 16'd1;
`endif
                    end else if (sclk_rise) begin
                        if (cyc_q == CW'(TIMEOUT - 1)) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            cyc_q   <= cyc_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (!CONT) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // Integration entry overrides the per-state updates above.
            if (go_integ) begin
                state_q      <= INTEG;
                st_q         <= 1'b1;
                busy_q       <= 1'b1;
                cyc_q        <= '0;
                pix_cnt_q    <= '0;
                start_pend_q <= 1'b0;
            end
        end
    end

    assign SENSOR_CLK  = sclk_q;
    assign ST          = st_q;
    assign PIX_VALID   = pix_valid_q;
    assign PIX_DATA    = pix_data_q;
    assign PIX_INDEX   = pix_index_q;
    assign FRAME_DONE  = frame_done_q;
    assign BUSY        = busy_q;
    assign ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Scoreboard bench for sensor_scan_ctrl: directed frames queue expected pixels/frames, a monitor pops and compares.
module tb_sensor_scan_ctrl;
    localparam int DIV       = 4;
    localparam int INTEG_CYC = 4;
    localparam int NPIX      = 4;
    localparam int TIMEOUT   = 16;
    localparam int LIMIT     = 2000;

    logic        clk = 1'b0;
    logic        rst, start, cont, trg, eoc;
    logic [11:0] adc;
    logic        sclk, st, pix_valid, frame_done, busy, err;
    logic [11:0] pix_data;
    logic [10:0] pix_index;
`ifdef SCAN_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    typedef struct {
        logic [10:0] idx;
        logic [11:0] data;
    } pix_t;

    pix_t pix_q[$];
    int   frame_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   exp_idx = 0;
    int   mon_pix = 0;
    int   exp_fcnt = 0;

    sensor_scan_ctrl #(.DIV(DIV), .INTEG_CYC(INTEG_CYC), .NPIX(NPIX), .TIMEOUT(TIMEOUT)) dut (
        .FPGA_CLK(clk), .FPGA_RST(rst), .START(start), .CONT(cont), .TRG(trg), .EOC(eoc),
        .ADC_DATA(adc), .SENSOR_CLK(sclk), .ST(st), .PIX_VALID(pix_valid), .PIX_DATA(pix_data),
        .PIX_INDEX(pix_index), .FRAME_DONE(frame_done), .BUSY(busy),
`ifdef SCAN_CTRL_FRAME_CNT_EN
        .FRAME_CNT(frame_cnt),
`endif
        .ERR_TIMEOUT(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a pixel or a frame end.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_pix = 0;
            end else begin
                if (pix_valid) begin
                    if (pix_q.size() == 0) begin
                        n_total++;
                        $display("FAIL pix_unexpected: index %0d data %0d, expected no pixel", pix_index, pix_data);
                    end else begin
                        pix_t p;
                        p = pix_q.pop_front();
                        check("pix_index", pix_index, p.idx);
                        check("pix_data", pix_data, p.data);
                    end
                    mon_pix++;
                end
                if (frame_done) begin
                    if (frame_q.size() == 0) begin
                        n_total++;
                        $display("FAIL frame_unexpected: FRAME_DONE seen, expected none");
                    end else begin
                        check("frame_pixels", mon_pix, frame_q.pop_front());
                    end
                    mon_pix = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_st(input logic lvl, input string name);
        int n = 0;
        while (st !== lvl && n < LIMIT) begin
            tick(1);
            n++;
        end
        if (n >= LIMIT) begin
            n_total++;
            $display("FAIL %s: ST stayed away from %0d for %0d cycles", name, lvl, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < LIMIT) begin
            tick(1);
            n++;
        end
        if (n >= LIMIT) begin
            n_total++;
            $display("FAIL %s: BUSY still high after %0d cycles, expected 0", name, n);
        end
    endtask

    task automatic pulse_trg(input logic [11:0] v);
        adc = v;
        trg = 1'b1;
        tick(4);
        trg = 1'b0;
        tick(4);
    endtask

    task automatic frame_pix(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            if (exp_idx < NPIX) begin
                pix_t p;
                p.idx  = 11'(exp_idx);
                p.data = 12'(base + i);
                pix_q.push_back(p);
                exp_idx++;
            end
            pulse_trg(12'(base + i));
        end
    endtask

    // One frame: optional START, measure ST width, TRG pulses, then EOC.
    task automatic run_frame(input int n, input int base, input bit use_start, input logic cont_after);
        int w = 0;
        if (use_start) do_start();
        wait_st(1'b1, "st_rise_wait");
        check("st_rise_on_sclk_rise", sclk, 1'b1);
        while (st === 1'b1 && w < LIMIT) begin
            tick(1);
            w++;
        end
        check("st_high_cycles", w, INTEG_CYC * 2 * DIV);
        cont = cont_after;
        exp_idx = 0;
        frame_pix(n, base);
        frame_q.push_back(n < NPIX ? n : NPIX);
        exp_fcnt++;
        eoc = 1'b1;
        tick(1);
        eoc = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; cont = 1'b0; trg = 1'b0; eoc = 1'b0; adc = '0;
        tick(3);
        check("rst_sclk", sclk, 0);
        check("rst_st", st, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_pix_index", pix_index, 0);
        check("rst_pix_data", pix_data, 0);

        // Sensor clock: first rise DIV cycles after release, then DIV high / DIV low.
        rst = 1'b0;
        n = 0;
        do begin tick(1); n++; end while (sclk !== 1'b1 && n < LIMIT);
        check("sclk_first_rise", n, DIV);
        n = 0;
        do begin tick(1); n++; end while (sclk !== 1'b0 && n < LIMIT);
        check("sclk_high_len", n, DIV);
        n = 0;
        do begin tick(1); n++; end while (sclk !== 1'b1 && n < LIMIT);
        check("sclk_low_len", n, DIV);

        // Normal frame with more TRG pulses than NPIX.
        run_frame(6, 256, 1'b1, 1'b0);
        wait_idle("frame_a_idle");
        check("frame_a_busy", busy, 0);
        check("frame_a_hold_index", pix_index, NPIX - 1);
        check("frame_a_hold_data", pix_data, 256 + NPIX - 1);
        check("frame_a_err", err, 0);

        // Timeout: no EOC after ST falls.
        do_start();
        wait_st(1'b1, "to_st_rise");
        wait_st(1'b0, "to_st_fall");
        n = 0;
        while (err !== 1'b1 && n < LIMIT) begin tick(1); n++; end
        check("timeout_cycles", n, TIMEOUT * 2 * DIV);
        tick(1);
        check("timeout_busy", busy, 0);
        check("timeout_err_sticky", err, 1);
        tick(20);
        check("timeout_err_held", err, 1);
        do_start();
        check("err_cleared_by_start", err, 0);
        run_frame(2, 768, 1'b0, 1'b0);
        wait_idle("after_err_idle");
        check("after_err_index", pix_index, 1);

        // Continuous mode: three frames from a single START.
        cont = 1'b1;
        run_frame(2, 1024, 1'b1, 1'b1);
        run_frame(3, 1280, 1'b0, 1'b1);
        run_frame(1, 1536, 1'b0, 1'b0);
        wait_idle("cont_idle");
        check("cont_busy", busy, 0);
`ifdef SCAN_CTRL_FRAME_CNT_EN
        check("frame_cnt_after_cont", frame_cnt, exp_fcnt);
`endif

        // Reset in the middle of readout, then a clean frame.
        do_start();
        wait_st(1'b1, "mid_st_rise");
        wait_st(1'b0, "mid_st_fall");
        exp_idx = 0;
        frame_pix(2, 2048);
        rst = 1'b1;
        tick(1);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_st", st, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_index", pix_index, 0);
        check("mid_rst_data", pix_data, 0);
        check("mid_rst_valid", pix_valid, 0);
        rst = 1'b0;
        exp_fcnt = 0;
        run_frame(3, 2304, 1'b1, 1'b0);
        wait_idle("post_rst_idle");
        check("post_rst_index", pix_index, 2);
        check("post_rst_data", pix_data, 2306);
`ifdef SCAN_CTRL_FRAME_CNT_EN
        check("frame_cnt_after_rst", frame_cnt, exp_fcnt);
`endif
        tick(4);
        check("scoreboard_empty", pix_q.size() + frame_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
